// File: rtl/handshake_muli_pipe.sv
// handshake_muli_pipe: joins lhs/rhs handshake channels and emits the signed product scaled by >>> FRAC_BITS.
// Latency: LATENCY cycles from accept to result_valid; one result per cycle while result_ready=1.
// Backpressure: whole pipe stalls when the last stage is full and result_ready=0; holds up to LATENCY items.
// Optional macro HANDSHAKE_MULI_SAT_EN: clamp out-of-range results instead of wrapping.
module handshake_muli_pipe #(
  parameter int DATA_WIDTH = 36,
  parameter int LATENCY    = 4,
  parameter int FRAC_BITS  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                  adv;
  logic                  fire;
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [DATA_WIDTH-1:0] lhs_q, lhs_d;
  logic [DATA_WIDTH-1:0] rhs_q, rhs_d;
  logic [PW-1:0]         lhs_ext, rhs_ext;
  logic [DATA_WIDTH-1:0] scaled_w;

  // Global stall: everything moves only when the output slot is free or draining.
  assign adv          = !vld_q[LATENCY-1] || result_ready;
  assign fire         = lhs_valid && rhs_valid && adv;
  // Each side is ready only when the partner is valid, so neither channel completes alone.
  assign lhs_ready    = rhs_valid && adv;
  assign rhs_ready    = lhs_valid && adv;
  assign result_valid = vld_q[LATENCY-1];

  // Stage 0 captures the operand pair; valid bits shift forward on every advancing cycle.
  always_comb begin
    vld_d = vld_q;
    lhs_d = lhs_q;
    rhs_d = rhs_q;
    if (adv) begin
      vld_d[0] = fire;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
      end
      if (fire) begin
        lhs_d = lhs;
        rhs_d = rhs;
      end
    end
  end

  // Stage 0 registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      lhs_q <= '0;
      rhs_q <= '0;
    end else begin
      vld_q <= vld_d;
      lhs_q <= lhs_d;
      rhs_q <= rhs_d;
    end
  end

  assign lhs_ext = {{DATA_WIDTH{lhs_q[DATA_WIDTH-1]}}, lhs_q};
  assign rhs_ext = {{DATA_WIDTH{rhs_q[DATA_WIDTH-1]}}, rhs_q};

`ifdef HANDSHAKE_MULI_SAT_EN
  logic [PW-1:0] shift_w;

  // Rescale the full product, then clamp when the kept bits would lose the sign.
  always_comb begin
    shift_w  = ($signed(lhs_ext) * $signed(rhs_ext)) >>> FRAC_BITS;
    scaled_w = shift_w[DATA_WIDTH-1:0];
    if (shift_w[PW-1:DATA_WIDTH-1] != {(PW-DATA_WIDTH+1){shift_w[PW-1]}}) begin
      scaled_w = shift_w[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  // Wrap: keep only the low result bits of the rescaled product.
  assign scaled_w = DATA_WIDTH'(($signed(lhs_ext) * $signed(rhs_ext)) >>> FRAC_BITS);
`endif

  if (LATENCY == 1) begin : g_lat1
    // Single stage: the held operands are the output stage, so the scaled value is stable under stall.
    assign result = scaled_w;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] res_q [LATENCY-1];
    logic [DATA_WIDTH-1:0] res_d [LATENCY-1];

    // Stage 1 captures the scaled product; later stages only delay it alongside the valid bits.
    always_comb begin
      for (int k = 0; k < LATENCY - 1; k++) begin
        res_d[k] = res_q[k];
      end
      if (adv) begin
        res_d[0] = scaled_w;
        for (int k = 1; k < LATENCY - 1; k++) begin
          res_d[k] = res_q[k-1];
        end
      end
    end

    // Result stage registers with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < LATENCY - 1; k++) begin
          res_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < LATENCY - 1; k++) begin
          res_q[k] <= res_d[k];
        end
      end
    end

    assign result = res_q[LATENCY-2];
  end

endmodule

// File: tb/tb_handshake_muli_pipe.sv
// Bench for handshake_muli_pipe: scoreboard on the default build plus a FRAC_BITS=16 instance.
module tb_handshake_muli_pipe;
  localparam int DW  = 36;
  localparam int LAT = 4;
  localparam logic signed [2*DW-1:0] MAXV = (72'sd1 <<< (DW-1)) - 72'sd1;
  localparam logic signed [2*DW-1:0] MINV = -(72'sd1 <<< (DW-1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] lhs, rhs, result;
  logic lhs_valid, lhs_ready, rhs_valid, rhs_ready, result_valid, result_ready;

  logic [DW-1:0] fx_lhs, fx_rhs, fx_result;
  logic fx_lhs_valid, fx_lhs_ready, fx_rhs_valid, fx_rhs_ready, fx_result_valid, fx_result_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accepted = 0;
  int delivered = 0;
  logic [DW-1:0] exp_q[$];
  int deliv_cyc[$];

  handshake_muli_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .FRAC_BITS(0)) dut (
    .clk(clk), .rst(rst),
    .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  handshake_muli_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .FRAC_BITS(16)) dut_fx (
    .clk(clk), .rst(rst),
    .lhs(fx_lhs), .lhs_valid(fx_lhs_valid), .lhs_ready(fx_lhs_ready),
    .rhs(fx_rhs), .rhs_valid(fx_rhs_valid), .rhs_ready(fx_rhs_ready),
    .result(fx_result), .result_valid(fx_result_valid), .result_ready(fx_result_ready)
  );

  // Reference arithmetic: exact signed product, arithmetic rescale, wrap or clamp.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b, input int frac);
    logic signed [2*DW-1:0] ea, eb, q;
    ea = $signed({{DW{a[DW-1]}}, a});
    eb = $signed({{DW{b[DW-1]}}, b});
    q  = (ea * eb) >>> frac;
`ifdef HANDSHAKE_MULI_SAT_EN
    if (q > MAXV) q = MAXV;
    if (q < MINV) q = MINV;
`endif
    return q[DW-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accepted pairs, pop on delivered results (sampled mid-cycle).
  always @(negedge clk) begin
    if (!rst) begin
      if (lhs_valid && lhs_ready) begin
        checks++;
        if (!(rhs_valid && rhs_ready)) begin
          failures++;
          $display("FAIL join_pair: rhs_valid&rhs_ready=%0b required 1", rhs_valid && rhs_ready);
        end
        exp_q.push_back(model(lhs, rhs, 0));
        accepted++;
      end
      if (result_valid && result_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: result=%h with nothing expected", result);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (result !== e) begin
            failures++;
            $display("FAIL sb_result: got %h required %h", result, e);
          end
        end
        delivered++;
        deliv_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !result_valid) break;
    end
    step();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lhs = '0; rhs = '0; lhs_valid = 0; rhs_valid = 0; result_ready = 0;
    fx_lhs = '0; fx_rhs = '0; fx_lhs_valid = 0; fx_rhs_valid = 0; fx_result_ready = 1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_out: valid=%b result=%h required 0/0", result_valid, result);
    end
    checks++;
    if (lhs_ready !== 1'b0 || rhs_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: lhs_ready=%b rhs_ready=%b required 0/0", lhs_ready, rhs_ready);
    end
  endtask

  task automatic test_basic();
    result_ready = 1;
    step();
    lhs = 36'd3; rhs = 36'd5; lhs_valid = 1; rhs_valid = 1;
    step();
    lhs_valid = 0; rhs_valid = 0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== (c == LAT)) begin
        failures++;
        $display("FAIL basic_latency: cycle %0d valid=%b required %b", c, result_valid, c == LAT);
      end
    end
    checks++;
    if (result !== 36'd15) begin
      failures++;
      $display("FAIL basic_value: got %h required %h", result, 36'd15);
    end
    drain();
  endtask

  task automatic test_signed_stream();
    bit ok;
    int d0;
    lhs = 36'hFFFFFFFFE; rhs = 36'd7; lhs_valid = 1; rhs_valid = 1;
    step();
    lhs_valid = 0; rhs_valid = 0;
    wait_valid(ok);
    checks++;
    if (!ok || result !== 36'hFFFFFFFF2) begin
      failures++;
      $display("FAIL signed_value: ok=%0b got %h required %h", ok, result, 36'hFFFFFFFF2);
    end
    drain();
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      lhs = DW'({$urandom(), $urandom()}); rhs = DW'({$urandom(), $urandom()});
      lhs_valid = 1; rhs_valid = 1;
      @(negedge clk);
      checks++;
      if (lhs_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready: item %0d lhs_ready=%b required 1", i, lhs_ready);
      end
      step();
    end
    lhs_valid = 0; rhs_valid = 0;
    drain();
    checks++;
    if (delivered - d0 != 8) begin
      failures++;
      $display("FAIL stream_count: got %0d required 8", delivered - d0);
    end else begin
      checks++;
      if (deliv_cyc[d0+7] - deliv_cyc[d0] != 7) begin
        failures++;
        $display("FAIL stream_consecutive: span %0d required 7", deliv_cyc[d0+7] - deliv_cyc[d0]);
      end
    end
  endtask

  task automatic test_join();
    int a0, d0;
    a0 = accepted; d0 = delivered;
    lhs = 36'd11; rhs = 36'd13; lhs_valid = 1; rhs_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (lhs_ready !== 1'b0 || result_valid !== 1'b0) begin
        failures++;
        $display("FAIL join_wait: lhs_ready=%b result_valid=%b required 0/0", lhs_ready, result_valid);
      end
      step();
    end
    rhs_valid = 1;
    @(negedge clk);
    checks++;
    if (lhs_ready !== 1'b1 || rhs_ready !== 1'b1) begin
      failures++;
      $display("FAIL join_fire: lhs_ready=%b rhs_ready=%b required 1/1", lhs_ready, rhs_ready);
    end
    step();
    lhs_valid = 0; rhs_valid = 0;
    drain();
    checks++;
    if (accepted - a0 != 1 || delivered - d0 != 1) begin
      failures++;
      $display("FAIL join_single: accepted=%0d delivered=%0d required 1/1", accepted - a0, delivered - d0);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pa [6];
    logic [DW-1:0] pb [6];
    int sent, d0;
    bit go;
    for (int i = 0; i < 6; i++) begin
      pa[i] = DW'(i * 1000 + 7);
      pb[i] = DW'(0 - (i + 3));
    end
    d0 = delivered;
    sent = 0;
    result_ready = 0;
    lhs = pa[0]; rhs = pb[0]; lhs_valid = 1; rhs_valid = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      go = lhs_valid && lhs_ready;
      step();
      if (go) begin
        sent++;
        if (sent < 6) begin lhs = pa[sent]; rhs = pb[sent]; end
      end
    end
    checks++;
    if (sent != LAT) begin
      failures++;
      $display("FAIL bp_accepted: got %0d required %0d", sent, LAT);
    end
    @(negedge clk);
    checks++;
    if (lhs_ready !== 1'b0 || rhs_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready: lhs_ready=%b rhs_ready=%b required 0/0", lhs_ready, rhs_ready);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (result_valid !== 1'b1 || result !== model(pa[0], pb[0], 0)) begin
        failures++;
        $display("FAIL bp_hold: valid=%b result=%h required 1/%h", result_valid, result, model(pa[0], pb[0], 0));
      end
      @(negedge clk);
    end
    step();
    result_ready = 1;
    for (int c = 0; c < 30 && sent < 6; c++) begin
      @(negedge clk);
      go = lhs_valid && lhs_ready;
      step();
      if (go) begin
        sent++;
        if (sent < 6) begin lhs = pa[sent]; rhs = pb[sent]; end
      end
    end
    lhs_valid = 0; rhs_valid = 0;
    drain();
    checks++;
    if (delivered - d0 != 6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_delivered: got %0d pending %0d required 6/0", delivered - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    result_ready = 1;
    for (int i = 0; i < 3; i++) begin
      lhs = DW'(i + 21); rhs = DW'(i + 4); lhs_valid = 1; rhs_valid = 1;
      step();
    end
    lhs_valid = 0; rhs_valid = 0;
    rst = 1;
    step();
    rst = 0;
    exp_q.delete();
    d0 = delivered;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_valid: got %b required 0", result_valid);
    end
    repeat (8) step();
    checks++;
    if (delivered != d0) begin
      failures++;
      $display("FAIL rst_mid_stale: delivered %0d stale results required 0", delivered - d0);
    end
  endtask

  task automatic test_sat_fixed();
    bit ok;
    logic [DW-1:0] want;
`ifdef HANDSHAKE_MULI_SAT_EN
    want = 36'h7FFFFFFFF;
`else
    want = 36'h000000000;
`endif
    lhs = 36'h300000000; rhs = 36'h300000000; lhs_valid = 1; rhs_valid = 1;
    step();
    lhs_valid = 0; rhs_valid = 0;
    wait_valid(ok);
    checks++;
    if (!ok || result !== want) begin
      failures++;
      $display("FAIL sat_pos: ok=%0b got %h required %h", ok, result, want);
    end
    drain();
    // Fixed-point instance: 2.0*2.0 and -1.5*2.0 in Q16.
    for (int t = 0; t < 2; t++) begin
      fx_lhs = (t == 0) ? 36'h000020000 : 36'hFFFFE8000;
      fx_rhs = 36'h000020000;
      want   = (t == 0) ? 36'h000040000 : 36'hFFFFD0000;
      fx_lhs_valid = 1; fx_rhs_valid = 1;
      step();
      fx_lhs_valid = 0; fx_rhs_valid = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (fx_result_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || fx_result !== want) begin
        failures++;
        $display("FAIL fixed_q16_%0d: ok=%0b got %h required %h", t, ok, fx_result, want);
      end
      step();
    end
  endtask

  task automatic test_random();
    int a0, d0;
    a0 = accepted; d0 = delivered;
    for (int c = 0; c < 400 && accepted - a0 < 40; c++) begin
      lhs = DW'({$urandom(), $urandom()});
      rhs = ($urandom_range(0, 3) == 0) ? DW'(0 - $urandom_range(1, 9)) : DW'({$urandom(), $urandom()});
      lhs_valid = $urandom_range(0, 3) != 0;
      rhs_valid = $urandom_range(0, 3) != 0;
      result_ready = $urandom_range(0, 2) != 0;
      step();
    end
    lhs_valid = 0; rhs_valid = 0; result_ready = 1;
    drain();
    checks++;
    if (accepted - a0 < 40 || delivered - d0 != accepted - a0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_flow: accepted=%0d delivered=%0d pending=%0d required >=40/equal/0",
               accepted - a0, delivered - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_stream();
    test_join();
    test_backpressure();
    test_reset_mid();
    test_sat_fixed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
